// File: rtl/render_chain_driver.sv
// render_chain_driver: head-of-chain source for the shape-renderer pipeline.
// Scans a raster of background pixels. Host register writes are buffered in
// a FIFO and injected only between frames, so no frame is ever rendered with
// partially updated shape state.
// Optional feature: define RENDER_DRV_FRAME_CNT_EN to add the frame_count
// output, which counts frames that have been scanned to completion.
module render_chain_driver #(
   parameter int          H_RES      = 1920,
   parameter int          V_RES      = 1080,
   parameter int          FIFO_DEPTH = 16,
   parameter logic [31:0] BG_COLOR   = 32'h0000_0000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enable,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [10:0]                   cmd_shape_id,
   input  logic [11:0]                   cmd_reg_id,
   input  logic [31:0]                   cmd_data,
   output logic                          program_out,
   output logic [10:0]                   x_out,
   output logic [11:0]                   y_out,
   output logic [31:0]                   data_out,
   output logic                          scan_active,
   output logic                          frame_start,
`ifdef RENDER_DRV_FRAME_CNT_EN
   output logic [15:0]                   frame_count,
`endif
   output logic [$clog2(FIFO_DEPTH):0]   cmd_pending
);

   localparam int               AW      = $clog2(FIFO_DEPTH);
   localparam logic [10:0]      X_LAST  = 11'(H_RES - 1);
   localparam logic [11:0]      Y_LAST  = 12'(V_RES - 1);
   localparam logic [AW:0]      DEPTH_C = (AW + 1)'(FIFO_DEPTH);
   localparam logic [AW:0]      ONE_C   = (AW + 1)'(1);

   typedef enum logic [1:0] {IDLE, PROGRAM, SCAN} state_t;

   typedef struct packed {
      logic [10:0] shape_id;
      logic [11:0] reg_id;
      logic [31:0] data;
   } cmd_t;

   cmd_t          mem [FIFO_DEPTH];
   cmd_t          cmd_in;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          push;
   logic          pop;

   state_t        state;
   logic [AW:0]   remaining;
   logic [10:0]   x_cnt;
   logic [11:0]   y_cnt;

   assign cmd_in      = '{shape_id: cmd_shape_id, reg_id: cmd_reg_id, data: cmd_data};
   assign cmd_ready   = (count < DEPTH_C);
   assign cmd_pending = count;
   assign push        = cmd_valid && cmd_ready;
   // Every PROGRAM cycle consumes exactly one entry; the snapshot guarantees it exists.
   assign pop         = (state == PROGRAM);

   // Command storage: written on accepted pushes only.
   // NOTE: the storage array carries no reset; only pointers and count define
   // which entries are valid, so clearing the data would buy nothing.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= cmd_in;
   end

   // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // Sequencer: chooses between idling, programming a snapshot of the FIFO and
   // scanning pixels; outputs are registered from the current state's action.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         remaining   <= '0;
         x_cnt       <= '0;
         y_cnt       <= '0;
         program_out <= 1'b0;
         scan_active <= 1'b0;
         frame_start <= 1'b0;
         x_out       <= '0;
         y_out       <= '0;
         data_out    <= '0;
      end else begin
         // NOTE: outputs default to the idle value each cycle, so each state
         // only names the outputs it drives and nothing holds stale data.
         program_out <= 1'b0;
         scan_active <= 1'b0;
         frame_start <= 1'b0;
         x_out       <= '0;
         y_out       <= '0;
         data_out    <= '0;
         case (state)
            IDLE: begin
               if (count != '0) begin
                  state     <= PROGRAM;
                  remaining <= count;
               end else if (enable) begin
                  state <= SCAN;
                  x_cnt <= '0;
                  y_cnt <= '0;
               end
            end
            PROGRAM: begin
               program_out <= 1'b1;
               x_out       <= mem[rd_ptr].shape_id;
               y_out       <= mem[rd_ptr].reg_id;
               data_out    <= mem[rd_ptr].data;
               remaining   <= remaining - 1'b1;
               // Commands pushed after the snapshot wait for the next blanking.
               if (remaining == ONE_C) begin
                  if (enable) begin
                     state <= SCAN;
                     x_cnt <= '0;
                     y_cnt <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            SCAN: begin
               scan_active <= 1'b1;
               x_out       <= x_cnt;
               y_out       <= y_cnt;
               data_out    <= BG_COLOR;
               frame_start <= (x_cnt == '0) && (y_cnt == '0);
               if (x_cnt == X_LAST) begin
                  x_cnt <= '0;
                  if (y_cnt == Y_LAST) begin
                     y_cnt <= '0;
                     // Frame boundary: pending commands first, then enable decides.
                     if (count != '0) begin
                        state     <= PROGRAM;
                        remaining <= count;
                     end else if (!enable) begin
                        state <= IDLE;
                     end
                  end else begin
                     y_cnt <= y_cnt + 1'b1;
                  end
               end else begin
                  x_cnt <= x_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef RENDER_DRV_FRAME_CNT_EN
   // Count a frame once its last pixel has been presented on the outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_count <= '0;
      end else if (scan_active && (x_out == X_LAST) && (y_out == Y_LAST)) begin
         frame_count <= frame_count + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_render_chain_driver.sv
// tb_render_chain_driver: self-checking bench for render_chain_driver with a
// 4x2 raster and a 4-entry FIFO. Directed vector table, hand-written
// corner sequences and a randomized run against a queue-based model.
module tb_render_chain_driver;

   localparam int          H  = 4;
   localparam int          V  = 2;
   localparam int          D  = 4;
   localparam logic [31:0] BG = 32'h00C0_FFEE;

   typedef struct packed {
      logic [10:0] sid;
      logic [11:0] rid;
      logic [31:0] dat;
   } cmd_t;

   typedef struct {
      bit          en;
      bit          v;
      cmd_t        c;
      logic [79:0] exp;
   } tv_t;

   typedef struct {
      bit prog;
      int x;
      int y;
   } ev_t;

   logic        clk;
   logic        rst;
   logic        enable;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [10:0] cmd_shape_id;
   logic [11:0] cmd_reg_id;
   logic [31:0] cmd_data;
   logic        program_out;
   logic [10:0] x_out;
   logic [11:0] y_out;
   logic [31:0] data_out;
   logic        scan_active;
   logic        frame_start;
   logic [2:0]  cmd_pending;
`ifdef RENDER_DRV_FRAME_CNT_EN
   logic [15:0] frame_count;
`endif

   int n_vec = 0;
   int n_mis = 0;
   int cyc   = 0;

   render_chain_driver #(.H_RES(H), .V_RES(V), .FIFO_DEPTH(D), .BG_COLOR(BG)) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_shape_id(cmd_shape_id), .cmd_reg_id(cmd_reg_id), .cmd_data(cmd_data),
      .program_out(program_out), .x_out(x_out), .y_out(y_out), .data_out(data_out),
      .scan_active(scan_active), .frame_start(frame_start),
`ifdef RENDER_DRV_FRAME_CNT_EN
      .frame_count(frame_count),
`endif
      .cmd_pending(cmd_pending)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model ----------------
   // The chain is seen as a plan of upcoming output events (pixels or
   // programming writes); when the plan runs dry, the next block is chosen
   // from the FIFO contents and enable as they stood before that edge.
   cmd_t        mq[$];
   ev_t         plan[$];
   logic        m_prog, m_scan, m_fs;
   logic [10:0] m_x;
   logic [11:0] m_y;
   logic [31:0] m_d;
   int          m_fc;

   function automatic logic [79:0] pk(logic p, logic [10:0] x, logic [11:0] y, logic [31:0] d,
                                      logic s, logic f, logic r, logic [2:0] n);
      return {18'h0, p, x, y, d, s, f, r, n};
   endfunction

   function automatic logic [79:0] dut_vec();
      return pk(program_out, x_out, y_out, data_out, scan_active, frame_start, cmd_ready, cmd_pending);
   endfunction

   function automatic logic [79:0] model_vec();
      return pk(m_prog, m_x, m_y, m_d, m_scan, m_fs, logic'(mq.size() < D), 3'(mq.size()));
   endfunction

   function automatic void plan_frame();
      for (int yy = 0; yy < V; yy++)
         for (int xx = 0; xx < H; xx++)
            plan.push_back('{prog: 1'b0, x: xx, y: yy});
   endfunction

   function automatic void plan_prog(int n);
      for (int i = 0; i < n; i++) plan.push_back('{prog: 1'b1, x: 0, y: 0});
   endfunction

   function automatic void model_reset();
      mq.delete();
      plan.delete();
      m_prog = 0; m_scan = 0; m_fs = 0; m_x = '0; m_y = '0; m_d = '0;
      m_fc = 0;
   endfunction

   function automatic void model_edge();
      bit   was_last;
      int   qb;
      ev_t  ev;
      cmd_t c;
      was_last = m_scan && (m_x == 11'(H - 1)) && (m_y == 12'(V - 1));
      if (rst) begin
         model_reset();
         return;
      end
      if (was_last) m_fc = (m_fc + 1) % 65536;
      qb = mq.size();
      m_prog = 0; m_scan = 0; m_fs = 0; m_x = '0; m_y = '0; m_d = '0;
      if (plan.size() == 0) begin
         if (qb > 0)      plan_prog(qb);
         else if (enable) plan_frame();
      end else begin
         ev = plan.pop_front();
         if (ev.prog) begin
            c = mq.pop_front();
            m_prog = 1; m_x = c.sid; m_y = c.rid; m_d = c.dat;
         end else begin
            m_scan = 1; m_x = 11'(ev.x); m_y = 12'(ev.y); m_d = BG;
            m_fs = (ev.x == 0) && (ev.y == 0);
         end
         if (plan.size() == 0) begin
            if (!ev.prog && qb > 0) plan_prog(qb);
            else if (enable)        plan_frame();
         end
      end
      if (cmd_valid && qb < D)
         mq.push_back('{sid: cmd_shape_id, rid: cmd_reg_id, dat: cmd_data});
   endfunction

   // ---------------- checking helpers ----------------
   task automatic check(string name, logic [79:0] act, logic [79:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic set_in(bit en, bit v, cmd_t c);
      enable       = en;
      cmd_valid    = v;
      cmd_shape_id = c.sid;
      cmd_reg_id   = c.rid;
      cmd_data     = c.dat;
   endtask

   // One clock: the model advances on the same edge and every output is compared.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      model_edge();
      check("model", dut_vec(), model_vec());
`ifdef RENDER_DRV_FRAME_CNT_EN
      check("frame_count", {64'h0, frame_count}, {64'h0, 16'(m_fc)});
`endif
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_in(0, 0, '0);
      step();
      step();
      rst = 1'b0;
   endtask

   function automatic tv_t tv(bit en, bit v, cmd_t c, logic p, logic s, logic f,
                              int x, int y, logic [31:0] d, int n);
      tv_t t;
      t.en = en; t.v = v; t.c = c;
      t.exp = pk(p, 11'(x), 12'(y), d, s, f, logic'(n < D), 3'(n));
      return t;
   endfunction

   localparam cmd_t NC = '0;
   localparam cmd_t CA = '{sid: 11'd3, rid: 12'd1, dat: 32'h0000_0010};
   localparam cmd_t CB = '{sid: 11'd3, rid: 12'd4, dat: 32'h00FF_00FF};
   localparam cmd_t CC = '{sid: 11'd5, rid: 12'd6, dat: 32'h0000_ABCD};

   tv_t  tbl [23];
   cmd_t fc_cmds [5];
   int   fi;
   int   prog_cnt;

   initial begin
      rst = 1'b1;
      set_in(0, 0, '0);
      model_reset();

      // Idle programming in push order, back-to-back frames, a late command mid-frame.
      tbl[0]  = tv(0, 1, CA, 0, 0, 0, 0, 0, 32'h0, 1);
      tbl[1]  = tv(0, 1, CB, 0, 0, 0, 0, 0, 32'h0, 2);
      tbl[2]  = tv(0, 0, NC, 1, 0, 0, 3, 1, 32'h0000_0010, 1);
      tbl[3]  = tv(1, 0, NC, 0, 0, 0, 0, 0, 32'h0, 1);
      tbl[4]  = tv(1, 0, NC, 1, 0, 0, 3, 4, 32'h00FF_00FF, 0);
      tbl[5]  = tv(1, 0, NC, 0, 1, 1, 0, 0, BG, 0);
      tbl[6]  = tv(1, 0, NC, 0, 1, 0, 1, 0, BG, 0);
      tbl[7]  = tv(1, 0, NC, 0, 1, 0, 2, 0, BG, 0);
      tbl[8]  = tv(1, 0, NC, 0, 1, 0, 3, 0, BG, 0);
      tbl[9]  = tv(1, 0, NC, 0, 1, 0, 0, 1, BG, 0);
      tbl[10] = tv(1, 0, NC, 0, 1, 0, 1, 1, BG, 0);
      tbl[11] = tv(1, 0, NC, 0, 1, 0, 2, 1, BG, 0);
      tbl[12] = tv(1, 0, NC, 0, 1, 0, 3, 1, BG, 0);
      tbl[13] = tv(1, 0, NC, 0, 1, 1, 0, 0, BG, 0);
      tbl[14] = tv(1, 0, NC, 0, 1, 0, 1, 0, BG, 0);
      tbl[15] = tv(1, 1, CC, 0, 1, 0, 2, 0, BG, 1);
      tbl[16] = tv(1, 0, NC, 0, 1, 0, 3, 0, BG, 1);
      tbl[17] = tv(1, 0, NC, 0, 1, 0, 0, 1, BG, 1);
      tbl[18] = tv(1, 0, NC, 0, 1, 0, 1, 1, BG, 1);
      tbl[19] = tv(1, 0, NC, 0, 1, 0, 2, 1, BG, 1);
      tbl[20] = tv(1, 0, NC, 0, 1, 0, 3, 1, BG, 1);
      tbl[21] = tv(1, 0, NC, 1, 0, 0, 5, 6, 32'h0000_ABCD, 0);
      tbl[22] = tv(1, 0, NC, 0, 1, 1, 0, 0, BG, 0);

      do_reset();
      check("reset_state", dut_vec(), pk(0, 0, 0, 0, 0, 0, 1, 0));
      for (int i = 0; i < 23; i++) begin
         set_in(tbl[i].en, tbl[i].v, tbl[i].c);
         step();
         check($sformatf("tbl%0d", i), dut_vec(), tbl[i].exp);
      end

      // Snapshot of 2 commands; a command pushed during programming waits a full frame.
      do_reset();
      for (int k = 0; k <= 20; k++) begin
         case (k)
            2:       set_in(1, 1, '{sid: 11'd10, rid: 12'd20, dat: 32'h1111_0001});
            3:       set_in(1, 1, '{sid: 11'd11, rid: 12'd21, dat: 32'h1111_0002});
            9:       set_in(1, 1, '{sid: 11'd12, rid: 12'd22, dat: 32'h1111_0003});
            default: set_in(1, 0, NC);
         endcase
         step();
         case (k)
            9:  check("snap_p1",   dut_vec(), pk(1, 10, 20, 32'h1111_0001, 0, 0, 1, 2));
            10: check("snap_p2",   dut_vec(), pk(1, 11, 21, 32'h1111_0002, 0, 0, 1, 1));
            11: check("snap_f0",   dut_vec(), pk(0, 0, 0, BG, 1, 1, 1, 1));
            18: check("snap_last", dut_vec(), pk(0, 3, 1, BG, 1, 0, 1, 1));
            19: check("snap_late", dut_vec(), pk(1, 12, 22, 32'h1111_0003, 0, 0, 1, 0));
            20: check("snap_f1",   dut_vec(), pk(0, 0, 0, BG, 1, 1, 1, 0));
            default: ;
         endcase
      end

      // FIFO full: four pushes fill it, the fifth is held until a pop frees a slot.
      for (int i = 0; i < 5; i++)
         fc_cmds[i] = '{sid: 11'(100 + i), rid: 12'(200 + i), dat: 32'hF000_0000 + 32'(i)};
      do_reset();
      fi = 0;
      for (int k = 0; k <= 22; k++) begin
         if (k >= 2 && fi < 5) set_in(1, 1, fc_cmds[fi]);
         else                  set_in(1, 0, NC);
         if (cmd_valid && cmd_ready) fi++;
         step();
         case (k)
            5:  check("full_ready", dut_vec(), pk(0, 0, 1, BG, 1, 0, 0, 4));
            8:  check("full_hold",  dut_vec(), pk(0, 3, 1, BG, 1, 0, 0, 4));
            9:  check("full_pop0",  dut_vec(), pk(1, 100, 200, 32'hF000_0000, 0, 0, 1, 3));
            10: check("full_pop1",  dut_vec(), pk(1, 101, 201, 32'hF000_0001, 0, 0, 1, 3));
            21: check("full_fifth", dut_vec(), pk(1, 104, 204, 32'hF000_0004, 0, 0, 1, 0));
            default: ;
         endcase
      end

      // Reset at pixel (2,1) with one command queued: abort, flush, restart clean.
      do_reset();
      for (int k = 0; k <= 7; k++) begin
         if (k == 2) set_in(1, 1, '{sid: 11'd7, rid: 12'd7, dat: 32'h7777_7777});
         else        set_in(1, 0, NC);
         step();
      end
      check("rst_pre", dut_vec(), pk(0, 2, 1, BG, 1, 0, 1, 1));
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_out", dut_vec(), pk(0, 0, 0, 0, 0, 0, 1, 0));
`ifdef RENDER_DRV_FRAME_CNT_EN
      check("rst_fc", {64'h0, frame_count}, 80'h0);
`endif
      prog_cnt = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (program_out) prog_cnt++;
         if (k == 1) check("rst_f0", dut_vec(), pk(0, 0, 0, BG, 1, 1, 1, 0));
      end
      check("rst_noprog", 80'(prog_cnt), 80'h0);

      // Randomized traffic, enable toggles and occasional resets against the model.
      enable = 1'b1;
      for (int k = 0; k < 1500; k++) begin
         rst = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 39) == 0) enable = ~enable;
         cmd_valid    = ($urandom_range(0, 2) == 0);
         cmd_shape_id = 11'($urandom);
         cmd_reg_id   = 12'($urandom);
         cmd_data     = $urandom;
         step();
      end
      rst = 1'b0;
      set_in(0, 0, NC);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

// File: doc/render_chain_driver.md
Name: render_chain_driver

Overview:
- Head-of-chain source for the shape-renderer pipeline.
- Generates the raster pixel stream (x, y, background colour) that feeds the first renderer stage.
- Drives shape-register programming writes into the same bus: program_out=1, x=shape ID, y=register ID, data=value.
- Buffers host commands in a FIFO and injects them only between frames, so no frame is rendered with partially updated shape state.

Parameters:
- H_RES, 1920, pixels per line; x range 0..H_RES-1.
- V_RES, 1080, lines per frame; y range 0..V_RES-1.
- FIFO_DEPTH, 16, command FIFO entries; power of two, minimum 2.
- BG_COLOR, 32'h00000000, data_out value for every scanned pixel.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  permits frame scanning.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_shape_id  in  11  target shape ID; driven onto x_out.
- cmd_reg_id  in  12  target register ID; driven onto y_out.
- cmd_data  in  32  register value.
- program_out  out  1  programming write marker to the chain.
- x_out  out  11  pixel x, or shape ID when programming.
- y_out  out  12  pixel y, or register ID when programming.
- data_out  out  32  BG_COLOR, or cmd_data when programming.
- scan_active  out  1  high on cycles where outputs carry a pixel.
- frame_start  out  1  one-cycle pulse aligned with pixel (0,0).
- cmd_pending  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset state: state=IDLE; FIFO flushed; all outputs 0 except cmd_ready=1.
- Reset mid-frame or mid-programming: aborts immediately; the next frame restarts at (0,0).
- All outputs are registered. A state decision made in cycle N appears on the outputs in cycle N+1.
- FIFO push: on cmd_valid && cmd_ready.
  - cmd_ready = (cmd_pending < FIFO_DEPTH).
  - Push and pop in the same cycle leave the count unchanged. This is legal when full, but cmd_ready stays low at full.
- IDLE:
  - FIFO non-empty → PROGRAM; latch snap = cmd_pending.
  - Else if enable → SCAN with x=y=0.
  - Else stay. Outputs program_out=0, scan_active=0, x_out/y_out/data_out=0.
- PROGRAM:
  - Pops one entry per cycle and emits program_out=1, x_out=shape_id, y_out=reg_id, data_out=data, scan_active=0.
  - Exactly snap entries are popped. Commands pushed during PROGRAM wait for the next blanking (anti-starvation).
  - After the last pop → SCAN if enable, else IDLE.
- SCAN:
  - One pixel per cycle: program_out=0, scan_active=1, data_out=BG_COLOR.
  - x increments; at H_RES-1, x wraps to 0 and y increments.
  - frame_start=1 only on the (0,0) output cycle.
  - After (H_RES-1, V_RES-1):
    - FIFO non-empty → PROGRAM (new snap).
    - Else if enable → next frame's (0,0) on the next cycle, with no bubble.
    - Else → IDLE.
- enable is sampled only at frame boundaries and in IDLE. Deasserting it mid-frame completes the current frame.
- Commands never interleave with pixels inside a frame.

Optional Feature:
- Macro: RENDER_DRV_FRAME_CNT_EN.
- Defined: adds output port frame_count [15:0].
  - Reset 0; increments by 1 in the cycle after each completed frame's last pixel.
  - Wraps 16'hFFFF→0.
  - Not incremented for a frame aborted by rst.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- All scenarios use H_RES=4, V_RES=2, FIFO_DEPTH=4.
- rst=1 for 2 cycles, enable=1, no commands → 8 pixels (0,0)..(3,1), data_out=BG_COLOR, frame_start once per 8 cycles, back-to-back frames with no gap.
- Push 2 commands (id 3/reg 1/32'h10, id 3/reg 4/32'hFF00FF) while idle, then enable → 2 program_out=1 cycles in push order, then pixel (0,0).
- Push a command at pixel (1,0) → not emitted until after pixel (3,1); then 1 programming cycle, then next frame.
- Push 5 commands with no pops → cmd_ready=0 after the 4th, cmd_pending=4, 5th held until a pop.
- Push during PROGRAM with snap=2 → exactly 2 pops, a full frame is scanned, then the late command is issued.
- rst asserted at pixel (2,1) with 1 command queued → outputs 0 next cycle, FIFO empty, the restarted frame begins at (0,0), and no programming cycle occurs. With RENDER_DRV_FRAME_CNT_EN defined, frame_count=0.
